// File: rtl/bus_copy_engine_pkg.sv
// bus_copy_engine_pkg: address map constants and FSM state encodings for the copy engine
package bus_copy_engine_pkg;
  localparam logic [63:0] INITIAL_SP = 64'd200;
  localparam logic [63:0] MEM_END    = 64'd255;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RDW  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] WRW  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;
endpackage

// File: rtl/bus_copy_engine.sv
// bus_copy_engine: data_bus initiator copying len words from src to dst, aborting on bus exception
module bus_copy_engine
  import bus_copy_engine_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [LEN_W-1:0]  words_done,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write,
  input  logic [DATA_W-1:0] bus_read,
  input  logic              bus_exception
);
  logic [2:0]        state;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q, src_i, dst_i;
  logic [LEN_W-1:0]  len_q, i, i_next;
  logic [DATA_W-1:0] data, wdata_q;
  assign i_next = i + LEN_W'(1);
  assign src_i  = src_q + ADDR_W'(i);
  assign dst_i  = dst_q + ADDR_W'(i);
  // Bus drive follows the state; addr/data registers keep the last presented values between accesses
  always_comb begin
    busy      = state == RD || state == RDW || state == WR || state == WRW;
    done      = state == DONE;
    error     = state == ERR;
    bus_rw    = state == WR;
    bus_addr  = state == RD ? src_i : state == WR ? dst_i : addr_q;
    bus_write = state == WR ? data : wdata_q;
  end
  // Copy FSM: one read then one write per word, wait cycles sample the registered responder
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      i          <= '0;
      data       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_addr   <= '0;
      words_done <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q      <= src;
          dst_q      <= dst;
          len_q      <= len;
          i          <= '0;
          words_done <= '0;
          err_addr   <= '0;
          state      <= len == '0 ? DONE : RD;
        end
        RD: begin
          addr_q <= src_i;
          state  <= RDW;
        end
        RDW: if (bus_exception) begin
          err_addr <= src_i;
          state    <= ERR;
        end else begin
          data  <= bus_read;
          state <= WR;
        end
        WR: begin
          addr_q  <= dst_i;
          wdata_q <= data;
          state   <= WRW;
        end
        WRW: if (bus_exception) begin
          err_addr <= dst_i;
          state    <= ERR;
        end else begin
          words_done <= i_next;
          if (i_next == len_q) state <= DONE;
          else begin
            i     <= i_next;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_copy_engine.sv
// tb_bus_copy_engine: per-cycle reference model plus directed copy scenarios against a memory responder
module tb_bus_copy_engine;
  import bus_copy_engine_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [63:0] src = 0, dst = 0;
  logic [15:0] len = 0;
  logic        busy, done, error, bus_rw;
  logic [63:0] err_addr, bus_addr, bus_write;
  logic [15:0] words_done;
  logic [63:0] bus_read = 0;
  logic        bus_exception = 0;
  int          checks = 0, failures = 0;
  logic [63:0] mem [0:255];
  logic [63:0] ref_mem [0:255];
  bit          act = 0, ok = 0, live = 0;
  int          t = 0, end_t = 0;
  logic [63:0] m_src = 0, m_dst = 0, m_err = 0, m_addr = 0, m_wr = 0, m_data = 0, fail = 0;
  logic [15:0] m_wd = 0;

  always #5 clk = ~clk;

  bus_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr), .words_done(words_done),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  function automatic logic [63:0] pat(input logic [63:0] a);
    return 64'hA5A5_0000_0000_0000 | a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Registered responder: words 0..MEM_END exist, anything above raises an exception next cycle
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = pat(64'(k));
    forever begin
      @(posedge clk);
      bus_exception <= bus_addr > MEM_END;
      if (bus_addr <= MEM_END) begin
        bus_read <= mem[bus_addr[7:0]];
        if (bus_rw) mem[bus_addr[7:0]] <= bus_write;
      end
    end
  end

  // Reference model: t counts cycles since acceptance, word w occupies t = 4w..4w+3
  initial begin
    logic [63:0] sa, da;
    int w;
    for (int k = 0; k < 256; k++) ref_mem[k] = pat(64'(k));
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        act = 0; m_err = 0; m_wd = 0; m_addr = 0; m_wr = 0; m_data = 0; live = 1;
      end else if (act) begin
        w  = t / 4;
        sa = m_src + 64'(w);
        da = m_dst + 64'(w);
        if (t == end_t) act = 0;
        else begin
          case (t % 4)
            0: m_addr = sa;
            1: if (sa <= MEM_END) m_data = ref_mem[sa[7:0]];
            2: begin m_addr = da; m_wr = m_data; end
            default: if (da <= MEM_END) begin ref_mem[da[7:0]] = m_data; m_wd = 16'(w + 1); end
          endcase
          if (t == end_t - 1 && !ok) m_err = fail;
          t++;
        end
      end else if (start && live) begin
        m_src = src; m_dst = dst; m_wd = 0; m_err = 0; ok = 1; end_t = 4 * int'(len);
        for (int k = 0; k < int'(len); k++) begin
          if (src + 64'(k) > MEM_END) begin ok = 0; end_t = 4 * k + 2; fail = src + 64'(k); break; end
          if (dst + 64'(k) > MEM_END) begin ok = 0; end_t = 4 * k + 4; fail = dst + 64'(k); break; end
        end
        t = 0; act = 1;
      end
    end
  end

  // Compare every DUT output against the model each cycle once reset has been seen
  initial forever begin
    bit run;
    int ph;
    @(negedge clk);
    if (live) begin
      run = act && t < end_t;
      ph  = t % 4;
      chk("busy", 64'(busy), 64'(run));
      chk("done", 64'(done), 64'(act && t == end_t && ok));
      chk("error", 64'(error), 64'(act && t == end_t && !ok));
      chk("bus_rw", 64'(bus_rw), 64'(run && ph == 2));
      chk("bus_addr", bus_addr, run && ph == 0 ? m_src + 64'(t / 4) : run && ph == 2 ? m_dst + 64'(t / 4) : m_addr);
      chk("bus_write", bus_write, run && ph == 2 ? m_data : m_wr);
      chk("words_done", 64'(words_done), 64'(m_wd));
      chk("err_addr", err_addr, m_err);
    end
  end

  task automatic run_cmd(input logic [63:0] s, input logic [63:0] d, input logic [15:0] l, output int cyc);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1; cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      start = 0;
      cyc++;
      if (done || error) break;
    end
  endtask

  initial begin
    int cyc, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_bus_rw", 64'(bus_rw), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_words", 64'(words_done), 0);
    chk("rst_err_addr", err_addr, 0);
    rst_n = 1;
    run_cmd(INITIAL_SP, INITIAL_SP + 16, 16'd4, cyc);
    chk("t1_latency", 64'(cyc), 17);
    chk("t1_done", 64'(done), 1);
    chk("t1_words", 64'(words_done), 4);
    chk("t1_mem_lit", mem[216], 64'hA5A5_0000_0000_00C8);
    for (int k = 0; k < 4; k++) chk("t1_mem", mem[216 + k], pat(64'(200 + k)));
    run_cmd(64'd100, 64'd110, 16'd0, cyc);
    chk("t2_latency", 64'(cyc), 1);
    chk("t2_done", 64'(done), 1);
    chk("t2_words", 64'(words_done), 0);
    run_cmd(MEM_END - 1, 64'd100, 16'd3, cyc);
    chk("t3_latency", 64'(cyc), 11);
    chk("t3_error", 64'(error), 1);
    chk("t3_err_addr", err_addr, 64'd256);
    chk("t3_words", 64'(words_done), 2);
    run_cmd(64'd10, MEM_END, 16'd2, cyc);
    chk("t4_latency", 64'(cyc), 9);
    chk("t4_error", 64'(error), 1);
    chk("t4_err_addr", err_addr, 64'd256);
    chk("t4_words", 64'(words_done), 1);
    chk("t4_mem", mem[255], 64'hA5A5_0000_0000_000A);
    @(negedge clk);
    src = 20; dst = 40; len = 3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    src = 60; dst = 80; len = 5; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && !error && n < 100) begin @(negedge clk); n++; end
    chk("t5_done", 64'(done), 1);
    chk("t5_words", 64'(words_done), 3);
    for (int k = 0; k < 3; k++) chk("t5_mem", mem[40 + k], pat(64'(20 + k)));
    chk("t5_untouched", mem[80], pat(64'd80));
    @(negedge clk);
    src = 30; dst = 50; len = 3; start = 1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      start = 0;
      n++;
      if (bus_rw) break;
    end
    chk("t6_in_wr", 64'(bus_rw), 1);
    rst_n = 0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_bus_rw", 64'(bus_rw), 0);
    chk("t6_words", 64'(words_done), 0);
    chk("t6_bus_addr", bus_addr, 0);
    chk("t6_bus_write", bus_write, 0);
    chk("t6_pulse", 64'({done, error}), 0);
    rst_n = 1;
    run_cmd(64'd5, 64'd6, 16'd1, cyc);
    chk("t6_latency", 64'(cyc), 5);
    chk("t6_done", 64'(done), 1);
    chk("t6_words_after", 64'(words_done), 1);
    repeat (3) @(negedge clk);
    chk("t6_mem", mem[6], 64'hA5A5_0000_0000_0005);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bus_copy_engine.md
Name: bus_copy_engine

Overview:
- Bus initiator for the data_bus port (rw/addr/read/write/exception); the counterpart of the data_bus responder.
- On command, copies LEN consecutive words from a source address to a destination address: each word is read over the bus, then written back.
- Sits beside the core as a simple block-move/DMA master and stops on the first bus exception.
- Address map constants come from memory_map.v.

Parameters:
- ADDR_W, 64, bus address width.
- DATA_W, 64, bus data width.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- src  input  ADDR_W  first source word address, latched on accepted start.
- dst  input  ADDR_W  first destination word address, latched on accepted start.
- len  input  LEN_W  number of words to copy, latched on accepted start.
- busy  output  1  high from the cycle after start is accepted until DONE/ERR.
- done  output  1  one-cycle pulse: copy finished without exception.
- error  output  1  one-cycle pulse: copy aborted on a bus exception.
- err_addr  output  ADDR_W  bus address that raised the exception; held until the next accepted start.
- words_done  output  LEN_W  words fully written; held after completion.
- bus_rw  output  1  0 = read, 1 = write (data_bus convention).
- bus_addr  output  ADDR_W  bus address.
- bus_write  output  DATA_W  write data.
- bus_read  input  DATA_W  read data; registered by the responder, valid the cycle after the address.
- bus_exception  input  1  registered by the responder; refers to the address presented the previous cycle.

Behaviour:
- Reset: rst_n low at posedge sets state to IDLE and clears all outputs to 0.
  - Reset takes priority over every other event.
  - A reset mid-copy aborts the copy: no done/error pulse, and bus_rw is 0 from the next cycle.
- States and transitions:
  - IDLE: start=1 latches src, dst and len, clears words_done and err_addr, then goes to RD. If len=0, it goes to DONE instead.
  - RD: drive bus_rw=0, bus_addr=src+i; go to RDW.
  - RDW: bus_rw=0.
    - If bus_exception: err_addr<=src+i, go to ERR.
    - Otherwise: data<=bus_read, go to WR.
  - WR: drive bus_rw=1, bus_addr=dst+i, bus_write=data; go to WRW.
  - WRW: bus_rw=0.
    - If bus_exception: err_addr<=dst+i, go to ERR.
    - Otherwise: words_done<=i+1. Go to DONE if i+1==len, else i<=i+1 and go to RD.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: error=1 for one cycle, then IDLE.
- Timing:
  - 4 cycles per word.
  - Total latency from the start cycle to the done pulse is 4*len+1 cycles (len=0 gives 1 cycle).
  - busy is low in IDLE and during the DONE/ERR cycle.
- Command handling: start while not in IDLE is ignored; a start in the same cycle as done/error is also ignored.
- Address arithmetic: src+i and dst+i are computed modulo 2^ADDR_W, so 64-bit wrap is silent. Out-of-map addresses are detected only through bus_exception from the responder.
- Bus outputs: bus_addr and bus_write hold their last values outside RD/WR; bus_rw is 1 only in WR.
- Overlapping ranges: no special handling; words are copied strictly ascending.

Decomposition:
- memory_map.v (shared include) holds INITIAL_SP, MEM_END and the state encodings (IDLE, RD, RDW, WR, WRW, DONE, ERR, 3 bits).
- No sub-module: a single FSM plus counter and data register.
- The bench instantiates bus_copy_engine against the existing data_bus.

Test Plan:
- Reset then start with src=INITIAL_SP, dst=INITIAL_SP+16, len=4 -> done pulses exactly 17 cycles after start; words_done=4; mem[dst+k]==mem[src+k] for k=0..3.
- len=0 -> done pulses the next cycle; bus_rw stays 0 throughout; no bus access.
- src=MEM_END-1, len=3 -> the read of MEM_END+1 raises an exception; error pulses; err_addr=MEM_END+1; words_done=2; done never asserts.
- dst=MEM_END, len=2 -> the write exception on MEM_END+1 gives error; err_addr=MEM_END+1; words_done=1.
- Second start pulsed while busy -> ignored; the first copy completes with the original src/dst/len.
- rst_n low during a WR cycle mid-copy -> next cycle: busy=0, bus_rw=0, all outputs 0, no done/error pulse; a subsequent start with len=1 works normally (done after 5 cycles).
